rom_pattern_sequencer: RTL and testbench

ROM_PATTERN_SEQUENCER -- requirements
Module: rom_pattern_sequencer

---
 rtl/rom_seq_pkg.sv | 16 +
 rtl/dwell_timer.sv | 31 +++
 rtl/rom_pattern_sequencer.sv | 139 +++++++++++++
 tb/tb_rom_pattern_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// rtl/rom_seq_pkg.sv - shared state type and default parameters for the ROM pattern sequencer
package rom_seq_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH  = 3;
  localparam int DEF_DWELL_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PRESENT = 3'd2,
    ST_DWELL   = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - saturating down-counter timing the idle gap after each accepted word
module dwell_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (count && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  // Expires on the cycle holding the final count, so a load of N yields N dwell cycles.
  assign expired = (r_count <= WIDTH'(1));

endmodule

// File: rtl/rom_pattern_sequencer.sv
// rtl/rom_pattern_sequencer.sv - walks an external async ROM and presents each word over a valid/ready handshake
module rom_pattern_sequencer
  import rom_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_q,
  output logic [DATA_WIDTH-1:0]  pat_data,
  output logic                   pat_valid,
  input  logic                   pat_ready,
  output logic                   busy,
  output logic                   done
);

  seq_state_t              r_state;
  seq_state_t              w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_rom_addr;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_pat_data;
  logic [DATA_WIDTH-1:0]   w_data_nxt;
  logic                    r_pat_valid;
  logic                    w_valid_nxt;
  logic                    w_load;
  logic                    w_count;
  logic                    w_clear;
  logic                    w_expired;
  logic                    w_advance;
  logic                    w_last;

  assign w_last = (r_rom_addr == {ADDR_WIDTH{1'b1}});

  dwell_timer #(
    .WIDTH(DWELL_WIDTH)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_clear),
    .load     (w_load),
    .load_val (dwell),
    .count    (w_count),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rom_addr  <= '0;
      r_pat_data  <= '0;
      r_pat_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rom_addr  <= w_addr_nxt;
      r_pat_data  <= w_data_nxt;
      r_pat_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_rom_addr;
    w_data_nxt  = r_pat_data;
    w_valid_nxt = r_pat_valid;
    w_load      = 1'b0;
    w_count     = 1'b0;
    w_clear     = 1'b0;
    w_advance   = 1'b0;

    // Stop outranks both a pending handshake and the dwell countdown.
    if ((r_state != ST_IDLE) && stop) begin
      w_state_nxt = ST_IDLE;
      w_addr_nxt  = '0;
      w_valid_nxt = 1'b0;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            w_state_nxt = ST_FETCH;
            w_addr_nxt  = '0;
          end
        end
        ST_FETCH: begin
          w_data_nxt  = rom_q;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (pat_ready) begin
            w_valid_nxt = 1'b0;
            if (dwell == '0) begin
              w_advance = 1'b1;
            end else begin
              w_load      = 1'b1;
              w_state_nxt = ST_DWELL;
            end
          end
        end
        ST_DWELL: begin
          w_count = 1'b1;
          if (w_expired) w_advance = 1'b1;
        end
        ST_DONE: begin
          w_addr_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_addr_nxt  = '0;
          w_valid_nxt = 1'b0;
        end
      endcase

      if (w_advance) begin
        if (w_last && !loop_en) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_addr_nxt  = r_rom_addr + ADDR_WIDTH'(1);
          w_state_nxt = ST_FETCH;
        end
      end
    end
  end

  assign rom_addr  = r_rom_addr;
  assign pat_data  = r_pat_data;
  assign pat_valid = r_pat_valid;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_rom_pattern_sequencer.sv
// tb/tb_rom_pattern_sequencer.sv - directed vector and sequence bench for rom_pattern_sequencer
module tb_rom_pattern_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [15:0] dwell;
  logic [2:0]  rom_addr;
  logic [7:0]  rom_q;
  logic [7:0]  pat_data;
  logic        pat_valid;
  logic        pat_ready;
  logic        busy;
  logic        done;

  logic [7:0]  rom_image [8];
  logic [7:0]  got [$];
  int          done_cnt;
  int          stall_cnt;
  int          n_checks;
  int          n_pass;

  typedef struct {
    logic       start;
    logic       stop;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       chk_data;
    logic [2:0] exp_addr;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [19];

  rom_pattern_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .dwell     (dwell),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .pat_data  (pat_data),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .busy      (busy),
    .done      (done)
  );

  assign rom_q = rom_image[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic st, input logic sp, input logic rdy, input logic v,
                              input logic [7:0] d, input logic cd, input logic [2:0] a,
                              input logic b);
    vec_t r;
    r.start = st; r.stop = sp; r.ready = rdy; r.exp_valid = v;
    r.exp_data = d; r.chk_data = cd; r.exp_addr = a; r.exp_busy = b;
    return r;
  endfunction

  // Drives one sequence, consuming words with optional stall at stall_addr and measuring gaps.
  task automatic run_seq(input int dw, input int stall_addr, input bit lp, input int nwords);
    int  gap;
    bit  after_hs;
    bit  finished;
    int  stall_left;
    got.delete();
    done_cnt   = 0;
    stall_cnt  = 0;
    gap        = 0;
    after_hs   = 1'b0;
    finished   = 1'b0;
    stall_left = 5;
    dwell      = 16'(dw);
    loop_en    = lp;
    pat_ready  = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 600 && !finished; c++) begin
      if (done) done_cnt++;
      if (pat_valid) begin
        if (after_hs) begin
          check("dwell_gap", gap, dw + 1);
          after_hs = 1'b0;
        end
        if ((int'(rom_addr) == stall_addr) && (stall_left > 0)) begin
          check("stall_data", pat_data, rom_image[stall_addr]);
          check("stall_addr", rom_addr, stall_addr);
          stall_left--;
          stall_cnt++;
          pat_ready = 1'b0;
        end else begin
          pat_ready = 1'b1;
          got.push_back(pat_data);
          after_hs = 1'b1;
          gap      = 0;
        end
      end else if (after_hs) begin
        gap++;
      end
      if (lp && (got.size() == nwords)) begin
        step();
        finished = 1'b1;
      end else if (!busy) begin
        finished = 1'b1;
      end else begin
        step();
      end
    end
    if (!finished) check("seq_timeout", 0, 1);
  endtask

  task automatic check_pass(input string tag);
    check({tag, "_count"}, got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check({tag, "_word"}, got[i], rom_image[i]);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    bit seen5;
    bit hit;
    n_checks = 0;
    n_pass   = 0;
    rom_image[0] = 8'hAA; rom_image[1] = 8'hF0; rom_image[2] = 8'h0F; rom_image[3] = 8'hCC;
    rom_image[4] = 8'hE7; rom_image[5] = 8'h18; rom_image[6] = 8'hB7; rom_image[7] = 8'hED;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; dwell = '0; pat_ready = 1'b0;

    //          start stop rdy  valid data   chkd addr busy
    vecs[0]  = mk(1, 0, 0, 0, 8'h00, 1, 3'd0, 1);
    vecs[1]  = mk(0, 0, 0, 1, 8'hAA, 1, 3'd0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 8'hAA, 1, 3'd0, 1);
    vecs[3]  = mk(0, 0, 1, 0, 8'hAA, 1, 3'd1, 1);
    vecs[4]  = mk(0, 0, 1, 1, 8'hF0, 1, 3'd1, 1);
    vecs[5]  = mk(1, 0, 1, 0, 8'hF0, 1, 3'd2, 1);
    vecs[6]  = mk(0, 0, 0, 1, 8'h0F, 1, 3'd2, 1);
    vecs[7]  = mk(0, 0, 0, 1, 8'h0F, 1, 3'd2, 1);
    vecs[8]  = mk(0, 0, 0, 1, 8'h0F, 1, 3'd2, 1);
    vecs[9]  = mk(0, 0, 0, 1, 8'h0F, 1, 3'd2, 1);
    vecs[10] = mk(0, 0, 0, 1, 8'h0F, 1, 3'd2, 1);
    vecs[11] = mk(0, 0, 1, 0, 8'h0F, 1, 3'd3, 1);
    vecs[12] = mk(0, 1, 0, 0, 8'h00, 0, 3'd0, 0);
    vecs[13] = mk(1, 1, 0, 0, 8'h00, 0, 3'd0, 0);
    vecs[14] = mk(1, 0, 0, 0, 8'h00, 0, 3'd0, 1);
    vecs[15] = mk(0, 1, 0, 0, 8'h00, 0, 3'd0, 0);
    vecs[16] = mk(1, 0, 1, 0, 8'h00, 0, 3'd0, 1);
    vecs[17] = mk(0, 0, 1, 1, 8'hAA, 1, 3'd0, 1);
    vecs[18] = mk(0, 1, 1, 0, 8'hAA, 0, 3'd0, 0);

    repeat (3) step();
    check("rst_addr", rom_addr, 0);
    check("rst_data", pat_data, 0);
    check("rst_valid", pat_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 19; i++) begin
      start = vecs[i].start; stop = vecs[i].stop; pat_ready = vecs[i].ready;
      step();
      check($sformatf("vec%0d_valid", i), pat_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_addr", i), rom_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_done", i), done, 0);
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), pat_data, vecs[i].exp_data);
    end
    start = 1'b0; stop = 1'b0; pat_ready = 1'b0;
    step();

    run_seq(0, -1, 0, 8);
    check_pass("single");

    run_seq(0, 2, 0, 8);
    check_pass("backpressure");
    check("stall_cycles", stall_cnt, 5);

    run_seq(3, -1, 0, 8);
    check_pass("dwell3");

    run_seq(0, -1, 1, 10);
    check("loop_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++) check("loop_word", got[i], rom_image[i % 8]);
    check("loop_done_cnt", done_cnt, 0);
    check("loop_busy_before_stop", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop_stop_valid", pat_valid, 0);
    check("loop_stop_busy", busy, 0);
    check("loop_stop_addr", rom_addr, 0);

    dwell = 16'd2; loop_en = 1'b0; pat_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    seen5 = 1'b0;
    hit   = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (pat_valid && (rom_addr == 3'd5)) seen5 = 1'b1;
      else if (seen5 && !pat_valid && busy) hit = 1'b1;
      if (!hit) step();
    end
    check("reached_dwell_addr5", hit, 1);
    check("dwell_addr5", rom_addr, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_addr", rom_addr, 0);
    check("midrst_data", pat_data, 0);
    check("midrst_valid", pat_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_idle", busy, 0);
    run_seq(0, -1, 0, 8);
    check("post_rst_first", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 8'hAA);
    check_pass("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
